sd_req_arbiter: RTL and testbench
=================================

Name: sd_req_arbiter

Overview:
- Sits directly downstream of the drive selector's per-drive SD block interface (sd_lba[], sd_blk_cnt[], sd_rd, sd_wr, sd_ack, sd_buff_din[]).
- Serialises up to NDR concurrent drive requests onto the single host block-device channel in round-robin order.
- Routes host ack and the buffer-write strobe back to the granted drive only, and muxes that drive's write data to the host.

Parameters:
- DRIVES, 2, number of drive channels; NDR = clamp(DRIVES,1,4), N = NDR-1.
- TIMEOUT_CYC, 24'd8_000_000, REQ-state ack timeout in clk_sys cycles; used only with SD_ARB_TIMEOUT_EN.

Ports:
- clk_sys  in  1  sole clock; all logic on posedge.
- reset_n  in  1  synchronous, active-low reset.
- drv_lba[NDR]  in  32  per-drive block address.
- drv_blk_cnt[NDR]  in  6  per-drive block count minus 1.
- drv_rd  in  N+1  per-drive read request, level.
- drv_wr  in  N+1  per-drive write request, level.
- drv_ack  out  N+1  per-drive ack; only the granted bit can be high.
- drv_buff_din[NDR]  in  8  per-drive write data.
- drv_buff_wr  out  N+1  host buff_wr gated to the granted drive.
- host_lba  out  32  latched address.
- host_blk_cnt  out  6  latched count.
- host_rd  out  1  host read request.
- host_wr  out  1  host write request.
- host_ack  in  1  host transfer-active ack.
- host_buff_wr  in  1  host buffer write strobe.
- host_buff_din  out  8  drv_buff_din[grant], combinational.
- busy  out  1  high in REQ or XFER.
- grant  out  2  index of the current or last granted drive.
- timeout_err  out  1  one-cycle pulse (feature only).

Behaviour:
Reset (reset_n low at an edge):
- State to IDLE.
- Outputs cleared: host_rd, host_wr, host_lba, host_blk_cnt, drv_ack, busy, timeout_err; grant=N, so drive 0 is scanned first.
- armed[] set to all 1s.
- Reset applies even mid-transfer; no completion is signalled.

Eligibility:
- pend[i] = (drv_rd[i] | drv_wr[i]) & armed[i].
- armed[i] clears when drive i's transfer completes.
- armed[i] sets on any cycle where drv_rd[i]=0 and drv_wr[i]=0. This prevents a re-grant while a drive is still holding its old level request.

States:
- IDLE:
  - Search pend[] starting at (grant+1) mod NDR, wrapping, for the first set bit.
  - On a hit at edge t: latch lba and blk_cnt, set dir = rd ? READ : WRITE (read wins if both are set), update grant, go to REQ.
  - host_rd or host_wr is high from cycle t+1.
- REQ:
  - Hold host_rd/host_wr and latched values stable.
  - On the first edge with host_ack=1: drop host_rd/host_wr (low the next cycle), go to XFER.
  - A drive dropping its request while in REQ does not cancel; the request is committed.
- XFER:
  - drv_ack[grant] = host_ack (registered, 1-cycle delay). Other drv_ack bits are 0.
  - drv_buff_wr[grant] = host_buff_wr (combinational). Other bits are 0.
  - On the edge host_ack=0 is seen: clear armed[grant], drv_ack[grant] goes low, return to IDLE.
  - The next grant can occur on the following edge, so there is a minimum of one idle cycle between host requests.
- busy = (state != IDLE).
- host_buff_din is driven in every state from drv_buff_din[grant].

Boundaries:
- NDR=1: round-robin degenerates to a single channel; grant is always 0.
- All drives requesting simultaneously are served in strict rotation; no drive waits more than N transfers.
- Drive indices >= NDR are never granted.
- A host_ack pulse while in IDLE is ignored.

Optional Feature:
Macro SD_ARB_TIMEOUT_EN.
- Defined:
  - A 24-bit counter clears on entry to REQ and increments each cycle in REQ.
  - At TIMEOUT_CYC-1 without host_ack: drop host_rd/host_wr, pulse timeout_err for 1 cycle, clear armed[grant], return to IDLE; drv_ack never rises.
- Undefined:
  - REQ waits indefinitely.
  - timeout_err is tied 0 and the counter is absent.

Test Plan:
- Single read, DRIVES=2: drv_rd[0]=1, drv_lba[0]=32'h165 at edge t → host_rd=1 and host_lba=32'h165 at t+1. host_ack high at t+5 → host_rd low at t+6, drv_ack[0] high at t+6. host_ack low → back to IDLE, busy=0.
- Round-robin: drv_rd=2'b11 held, host acks each request → grants 0,1,0,1. Each drive de-asserts between grants, re-arming it. host_lba alternates between the two drives' addresses.
- Re-arm guard: drv_wr[1] held high after completion → no second host_wr. Drop drv_wr[1] for 1 cycle, then re-raise → new host_wr exactly 1 cycle after the re-raise edge.
- Write data path: grant=1, drv_buff_din[1]=8'hA5, drv_buff_din[0]=8'h3C, host_buff_wr pulses → host_buff_din=8'hA5, drv_buff_wr=2'b10.
- Reset mid-XFER: reset_n low for 1 edge during host_ack=1 → all outputs 0, grant=N. A subsequent drv_rd[0] is granted normally.
- Timeout (SD_ARB_TIMEOUT_EN, TIMEOUT_CYC=16): drv_rd[0] with host_ack never asserted → host_rd low and timeout_err=1 for exactly 1 cycle, 16 cycles after host_rd rose. State returns to IDLE.

Source files
------------

// File: rtl/sd_req_arbiter.sv
// sd_req_arbiter: round-robin serialiser of per-drive SD block requests onto one host block channel.
// Define SD_ARB_TIMEOUT_EN to abandon a request whose host_ack never arrives within TIMEOUT_CYC cycles.
module sd_req_arbiter #(
   parameter int          DRIVES      = 2,
   parameter logic [23:0] TIMEOUT_CYC = 24'd8_000_000,
   localparam int         NDR         = (DRIVES < 1) ? 1 : ((DRIVES > 4) ? 4 : DRIVES),
   localparam int         N           = NDR - 1
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic [31:0] drv_lba [NDR],
   input  logic [5:0]  drv_blk_cnt [NDR],
   input  logic [N:0]  drv_rd,
   input  logic [N:0]  drv_wr,
   output logic [N:0]  drv_ack,
   input  logic [7:0]  drv_buff_din [NDR],
   output logic [N:0]  drv_buff_wr,
   output logic [31:0] host_lba,
   output logic [5:0]  host_blk_cnt,
   output logic        host_rd,
   output logic        host_wr,
   input  logic        host_ack,
   input  logic        host_buff_wr,
   output logic [7:0]  host_buff_din,
   output logic        busy,
   output logic [1:0]  grant,
   output logic        timeout_err,
   output logic [1:0]  state_dbg
);

   // Handshake: a drive holds rd/wr as a level until its transfer completes. host_rd/host_wr is
   // held until host_ack is first seen high; host_ack then stays high for the whole transfer and
   // its fall marks completion. A drive must drop its request once before it can be granted again.
   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, XFER = 2'd2} state_t;

   state_t      state;
   logic [N:0]  armed;
   logic [N:0]  pend;
   logic [N:0]  idle_req;
   logic [N:0]  grant_oh;
   logic [3:0]  pend_ext;
   logic        hit;
   logic [1:0]  next_idx;
   logic [1:0]  cand;
   logic [31:0] sel_lba;
   logic [5:0]  sel_cnt;
   logic        sel_rd;

   assign idle_req  = ~(drv_rd | drv_wr);
   assign pend      = (drv_rd | drv_wr) & armed;
   assign state_dbg = state;

   // Rotating search: start one past the last grant so every drive is reached within NDR steps.
   always_comb begin
      pend_ext      = '0;
      pend_ext[N:0] = pend;
      hit           = 1'b0;
      next_idx      = grant;
      cand          = 2'd0;
      for (int k = 1; k <= NDR; k++) begin
         cand = 2'((int'(grant) + k) % NDR);
         if (!hit && pend_ext[cand]) begin
            hit      = 1'b1;
            next_idx = cand;
         end
      end
   end

   always_comb begin
      sel_lba       = '0;
      sel_cnt       = '0;
      sel_rd        = 1'b0;
      host_buff_din = '0;
      grant_oh      = '0;
      for (int i = 0; i < NDR; i++) begin
         if (next_idx == 2'(i)) begin
            sel_lba = drv_lba[i];
            sel_cnt = drv_blk_cnt[i];
            sel_rd  = drv_rd[i];
         end
         if (grant == 2'(i)) begin
            host_buff_din = drv_buff_din[i];
            grant_oh[i]   = 1'b1;
         end
      end
   end

   assign drv_buff_wr = (state == XFER && host_buff_wr) ? grant_oh : '0;

`ifdef SD_ARB_TIMEOUT_EN
   logic [23:0] to_cnt;
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYC;
   assign timeout_err    = 1'b0;
`endif

   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         state        <= IDLE;
         host_rd      <= 1'b0;
         host_wr      <= 1'b0;
         host_lba     <= '0;
         host_blk_cnt <= '0;
         drv_ack      <= '0;
         busy         <= 1'b0;
         grant        <= 2'(N);
         armed        <= '1;
`ifdef SD_ARB_TIMEOUT_EN
         timeout_err  <= 1'b0;
         to_cnt       <= '0;
`endif
      end else begin
         armed <= armed | idle_req;
`ifdef SD_ARB_TIMEOUT_EN
         timeout_err <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (hit) begin
                  host_lba     <= sel_lba;
                  host_blk_cnt <= sel_cnt;
                  host_rd      <= sel_rd;
                  host_wr      <= !sel_rd;
                  grant        <= next_idx;
                  busy         <= 1'b1;
                  state        <= REQ;
`ifdef SD_ARB_TIMEOUT_EN
                  to_cnt       <= '0;
`endif
               end
            end
            REQ: begin
               if (host_ack) begin
                  host_rd <= 1'b0;
                  host_wr <= 1'b0;
                  drv_ack <= grant_oh;
                  state   <= XFER;
               end
`ifdef SD_ARB_TIMEOUT_EN
               else if (to_cnt == TIMEOUT_CYC - 24'd1) begin
                  host_rd     <= 1'b0;
                  host_wr     <= 1'b0;
                  timeout_err <= 1'b1;
                  armed       <= (armed | idle_req) & ~grant_oh;
                  busy        <= 1'b0;
                  state       <= IDLE;
               end else begin
                  to_cnt <= to_cnt + 24'd1;
               end
`endif
            end
            XFER: begin
               if (host_ack) begin
                  drv_ack <= grant_oh;
               end else begin
                  drv_ack <= '0;
                  armed   <= (armed | idle_req) & ~grant_oh;
                  busy    <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sd_req_arbiter.sv
// Bench for sd_req_arbiter: directed scenarios with literal expectations plus a cycle model
// of the arbitration rules compared against every output on each falling clock edge.
module tb_sd_req_arbiter;

   localparam int DRIVES = 2;
   localparam int NDR    = 2;
   localparam int TO_CYC = 16;

   logic        clk_sys = 1'b0;
   logic        reset_n;
   logic [31:0] drv_lba [NDR];
   logic [5:0]  drv_blk_cnt [NDR];
   logic [1:0]  drv_rd;
   logic [1:0]  drv_wr;
   logic [1:0]  drv_ack;
   logic [7:0]  drv_buff_din [NDR];
   logic [1:0]  drv_buff_wr;
   logic [31:0] host_lba;
   logic [5:0]  host_blk_cnt;
   logic        host_rd;
   logic        host_wr;
   logic        host_ack;
   logic        host_buff_wr;
   logic [7:0]  host_buff_din;
   logic        busy;
   logic [1:0]  grant;
   logic        timeout_err;
   logic [1:0]  state_dbg;

   int          checks = 0;
   int          errors = 0;
   bit          cmp_en = 1'b0;
   logic [31:0] exp_q[$];

   // Clock / reset
   always #5 clk_sys = ~clk_sys;

   sd_req_arbiter #(
      .DRIVES      (DRIVES),
      .TIMEOUT_CYC (24'(TO_CYC))
   ) dut (
      .clk_sys       (clk_sys),
      .reset_n       (reset_n),
      .drv_lba       (drv_lba),
      .drv_blk_cnt   (drv_blk_cnt),
      .drv_rd        (drv_rd),
      .drv_wr        (drv_wr),
      .drv_ack       (drv_ack),
      .drv_buff_din  (drv_buff_din),
      .drv_buff_wr   (drv_buff_wr),
      .host_lba      (host_lba),
      .host_blk_cnt  (host_blk_cnt),
      .host_rd       (host_rd),
      .host_wr       (host_wr),
      .host_ack      (host_ack),
      .host_buff_wr  (host_buff_wr),
      .host_buff_din (host_buff_din),
      .busy          (busy),
      .grant         (grant),
      .timeout_err   (timeout_err),
      .state_dbg     (state_dbg)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: phase 0 = waiting, 1 = host request outstanding, 2 = transfer running
   int          m_phase;
   int          m_grant;
   int          m_req_cycles;
   bit [3:0]    m_armed;
   logic        m_rd, m_wr, m_busy, m_terr;
   logic [31:0] m_lba;
   logic [5:0]  m_cnt;
   logic [1:0]  m_ack;

   always @(posedge clk_sys) begin
      bit [3:0] was_armed;
      int       pick;
      int       c;
      if (!reset_n) begin
         m_phase = 0; m_grant = NDR - 1; m_req_cycles = 0; m_armed = '1;
         m_rd = 0; m_wr = 0; m_busy = 0; m_terr = 0; m_lba = 0; m_cnt = 0; m_ack = 0;
      end else begin
         was_armed = m_armed;
         m_terr    = 0;
         for (int i = 0; i < NDR; i++)
            if (!drv_rd[i] && !drv_wr[i]) m_armed[i] = 1'b1;
         case (m_phase)
            0: begin
               pick = -1;
               for (int j = 1; j <= NDR; j++) begin
                  c = (m_grant + j) % NDR;
                  if (pick < 0 && (drv_rd[c] || drv_wr[c]) && was_armed[c]) pick = c;
               end
               if (pick >= 0) begin
                  m_grant = pick; m_lba = drv_lba[pick]; m_cnt = drv_blk_cnt[pick];
                  m_rd = drv_rd[pick]; m_wr = !drv_rd[pick];
                  m_phase = 1; m_busy = 1; m_req_cycles = 0;
               end
            end
            1: begin
               if (host_ack) begin
                  m_rd = 0; m_wr = 0; m_phase = 2; m_ack = 2'b01 << m_grant;
               end
`ifdef SD_ARB_TIMEOUT_EN
               else begin
                  m_req_cycles++;
                  if (m_req_cycles == TO_CYC) begin
                     m_rd = 0; m_wr = 0; m_terr = 1; m_armed[m_grant] = 1'b0;
                     m_phase = 0; m_busy = 0;
                  end
               end
`endif
            end
            default: begin
               if (host_ack) m_ack = 2'b01 << m_grant;
               else begin
                  m_ack = 0; m_armed[m_grant] = 1'b0; m_phase = 0; m_busy = 0;
               end
            end
         endcase
      end
   end

   // Scoreboard compare on the falling edge
   always @(negedge clk_sys) begin
      logic [1:0] e_bw;
      if (cmp_en) begin
         e_bw = (m_phase == 2 && host_buff_wr) ? (2'b01 << m_grant) : 2'b00;
         chk("m_host_rd",       host_rd,       m_rd);
         chk("m_host_wr",       host_wr,       m_wr);
         chk("m_host_lba",      host_lba,      m_lba);
         chk("m_host_blk_cnt",  host_blk_cnt,  m_cnt);
         chk("m_drv_ack",       drv_ack,       m_ack);
         chk("m_busy",          busy,          m_busy);
         chk("m_grant",         grant,         m_grant);
         chk("m_timeout_err",   timeout_err,   m_terr);
         chk("m_drv_buff_wr",   drv_buff_wr,   e_bw);
         chk("m_host_buff_din", host_buff_din, drv_buff_din[m_grant]);
      end
   end

   // Driver tasks
   task automatic tick(input int n);
      repeat (n) @(posedge clk_sys);
      #1;
   endtask

   task automatic wait_req(input string name);
      int n = 0;
      while (!(host_rd || host_wr) && n < 20) begin
         tick(1);
         n++;
      end
      chk(name, 32'(host_rd | host_wr), 32'd1);
   endtask

   task automatic finish_xfer();
      host_ack = 1'b1;
      tick(2);
      host_ack = 1'b0;
      tick(1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time %0t exceeds limit 100000", $time);
      $fatal(1);
   end

   initial begin
      int g;
      reset_n = 1'b0; drv_rd = '0; drv_wr = '0; host_ack = 1'b0; host_buff_wr = 1'b0;
      for (int i = 0; i < NDR; i++) begin
         drv_lba[i] = '0; drv_blk_cnt[i] = '0; drv_buff_din[i] = '0;
      end
      tick(3);
      cmp_en = 1'b1;
      chk("rst_grant", grant, 32'd1);
      chk("rst_busy", busy, 32'd0);
      chk("rst_host_rd", host_rd, 32'd0);
      chk("rst_host_lba", host_lba, 32'd0);
      reset_n = 1'b1;
      tick(1);

      // Single read on drive 0
      drv_lba[0] = 32'h165; drv_blk_cnt[0] = 6'd3; drv_rd[0] = 1'b1;
      tick(1);
      chk("rd_host_rd", host_rd, 32'd1);
      chk("rd_host_lba", host_lba, 32'h165);
      chk("rd_blk_cnt", host_blk_cnt, 32'd3);
      chk("rd_grant", grant, 32'd0);
      tick(4);
      chk("rd_held", host_rd, 32'd1);
      host_ack = 1'b1;
      tick(1);
      chk("rd_rd_drop", host_rd, 32'd0);
      chk("rd_drv_ack", drv_ack, 32'h1);
      drv_buff_din[0] = 8'h5A; host_buff_wr = 1'b1; #1;
      chk("rd_buff_wr", drv_buff_wr, 32'h1);
      chk("rd_buff_din", host_buff_din, 32'h5A);
      host_buff_wr = 1'b0;
      host_ack = 1'b0;
      tick(1);
      chk("rd_ack_low", drv_ack, 32'd0);
      chk("rd_idle", busy, 32'd0);
      tick(2);
      chk("rd_no_regrant", host_rd, 32'd0);
      drv_rd[0] = 1'b0;
      tick(1);

      // Write on drive 1, data path, then the re-arm guard
      drv_lba[1] = 32'h2B00; drv_blk_cnt[1] = 6'd0; drv_wr[1] = 1'b1;
      drv_buff_din[1] = 8'hA5; drv_buff_din[0] = 8'h3C;
      tick(1);
      chk("wr_host_wr", host_wr, 32'd1);
      chk("wr_grant", grant, 32'd1);
      chk("wr_host_lba", host_lba, 32'h2B00);
      host_ack = 1'b1;
      tick(1);
      chk("wr_drv_ack", drv_ack, 32'h2);
      host_buff_wr = 1'b1; #1;
      chk("wr_buff_din", host_buff_din, 32'hA5);
      chk("wr_buff_wr", drv_buff_wr, 32'h2);
      host_buff_wr = 1'b0; #1;
      chk("wr_buff_wr_low", drv_buff_wr, 32'h0);
      tick(1);
      host_ack = 1'b0;
      tick(1);
      chk("wr_done", busy, 32'd0);
      tick(3);
      chk("guard_no_wr", host_wr, 32'd0);
      drv_wr[1] = 1'b0;
      tick(1);
      chk("guard_dropped", host_wr, 32'd0);
      drv_wr[1] = 1'b1;
      tick(1);
      chk("guard_rewr", host_wr, 32'd1);
      chk("guard_grant", grant, 32'd1);
      finish_xfer();
      drv_wr[1] = 1'b0;
      tick(1);

      // Round-robin with both drives requesting
      drv_lba[0] = 32'hA000; drv_lba[1] = 32'hB111; drv_rd = 2'b11;
      exp_q = '{32'hA000, 32'hB111, 32'hA000, 32'hB111, 32'hA000};
      for (int k = 0; k < 5; k++) begin
         wait_req("rr_req");
         chk("rr_grant", grant, 32'(k % 2));
         chk("rr_lba", host_lba, exp_q.pop_front());
         g = int'(grant);
         finish_xfer();
         if (k == 4) drv_rd = 2'b00;
         else begin
            drv_rd[g] = 1'b0;
            tick(1);
            drv_rd[g] = 1'b1;
         end
      end
      tick(2);
      chk("rr_idle", busy, 32'd0);

      // host_ack pulse while idle
      host_ack = 1'b1;
      tick(1);
      host_ack = 1'b0;
      tick(1);
      chk("idle_ack_busy", busy, 32'd0);
      chk("idle_ack_drv", drv_ack, 32'd0);

      // Reset in the middle of a transfer
      drv_lba[0] = 32'h777; drv_rd[0] = 1'b1;
      tick(1);
      chk("mid_host_rd", host_rd, 32'd1);
      host_ack = 1'b1;
      tick(1);
      chk("mid_drv_ack", drv_ack, 32'h1);
      reset_n = 1'b0;
      tick(1);
      chk("mid_rst_ack", drv_ack, 32'd0);
      chk("mid_rst_busy", busy, 32'd0);
      chk("mid_rst_grant", grant, 32'd1);
      chk("mid_rst_lba", host_lba, 32'd0);
      reset_n = 1'b1; host_ack = 1'b0;
      tick(1);
      chk("post_rst_rd", host_rd, 32'd1);
      chk("post_rst_grant", grant, 32'd0);
      chk("post_rst_lba", host_lba, 32'h777);
      finish_xfer();
      drv_rd = 2'b00;
      tick(1);

`ifdef SD_ARB_TIMEOUT_EN
      drv_rd[0] = 1'b1;
      tick(1);
      chk("to_rd_rise", host_rd, 32'd1);
      tick(15);
      chk("to_held", host_rd, 32'd1);
      chk("to_not_yet", timeout_err, 32'd0);
      tick(1);
      chk("to_rd_drop", host_rd, 32'd0);
      chk("to_pulse", timeout_err, 32'd1);
      chk("to_busy", busy, 32'd0);
      tick(1);
      chk("to_pulse_end", timeout_err, 32'd0);
      chk("to_no_regrant", host_rd, 32'd0);
      chk("to_no_ack", drv_ack, 32'd0);
      drv_rd = 2'b00;
      tick(2);
`endif

      cmp_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
